d_phy_hs_tx_sequencer: RTL and testbench

Sequences one D-PHY data lane through the LP→HS→LP transmission cycle for each CSI-2 packet produced by the protocol layer. It sits between the protocol layer's byte stream and the master adapter's line drivers. It generates the LP-11/LP-01/LP-00 entry states, HS-zero, the sync byte, the payload, HS-trail and HS-exit. All timing intervals are counted in byte-clock cycles.

---
 rtl/d_phy_hs_tx_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_d_phy_hs_tx_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d_phy_hs_tx_sequencer.sv
// D-PHY data-lane HS transmit sequencer: walks one lane through
// LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> LP-11 per packet.
module d_phy_hs_tx_sequencer #(
  parameter int          T_LPX      = 4,
  parameter int          T_HS_ZERO  = 6,
  parameter int          T_HS_TRAIL = 5,
  parameter int          T_HS_EXIT  = 8,
  parameter int          CNT_W      = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'hB8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       lp_dp,
  output logic       lp_dn,
  output logic       hs_en,
  output logic [7:0] hs_data,
  output logic       hs_valid,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [2:0] {
    IDLE,
    LP01,
    LP00,
    HS_ZERO,
    SYNC,
    DATA,
    TRAIL,
    EXIT
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timer_done;
  logic             last_seen;
  logic             last_msb;
  logic             accept;

  logic             nxt_lp_dp;
  logic             nxt_lp_dn;
  logic             nxt_hs_en;
  logic [7:0]       nxt_hs_data;
  logic             nxt_hs_valid;
  logic             nxt_underrun;

  assign timer_done = (cnt == '0);
  assign byte_ready = (state == SYNC) || ((state == DATA) && !last_seen);
  assign accept     = byte_ready && byte_valid;
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req)        next_state = LP01;
      LP01:    if (timer_done) next_state = LP00;
      LP00:    if (timer_done) next_state = HS_ZERO;
      HS_ZERO: if (timer_done) next_state = SYNC;
      SYNC:                    next_state = DATA;
      DATA:    if (last_seen)  next_state = TRAIL;
      TRAIL:   if (timer_done) next_state = EXIT;
      EXIT:    if (timer_done) next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // Interval counter reloads on every state change, otherwise counts down to 0.
  always_comb begin
    cnt_nxt = cnt;
    if (next_state != state) begin
      unique case (next_state)
        LP01, LP00: cnt_nxt = CNT_W'(T_LPX - 1);
        HS_ZERO:    cnt_nxt = CNT_W'(T_HS_ZERO - 1);
        TRAIL:      cnt_nxt = CNT_W'(T_HS_TRAIL - 1);
        EXIT:       cnt_nxt = CNT_W'(T_HS_EXIT - 1);
        default:    cnt_nxt = '0;
      endcase
    end else if (!timer_done) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  // Line levels are decoded from next_state and registered, so they change
  // on the same edge as the state register and never glitch.
  always_comb begin
    nxt_lp_dp    = 1'b0;
    nxt_lp_dn    = 1'b0;
    nxt_hs_en    = 1'b0;
    nxt_hs_data  = 8'h00;
    nxt_hs_valid = 1'b0;
    nxt_underrun = (state == DATA) && byte_ready && !byte_valid;
    unique case (next_state)
      IDLE, EXIT: begin
        nxt_lp_dp = 1'b1;
        nxt_lp_dn = 1'b1;
      end
      LP01: begin
        nxt_lp_dn = 1'b1;
      end
      LP00: begin
      end
      HS_ZERO: begin
        nxt_hs_en    = 1'b1;
        nxt_hs_valid = 1'b1;
      end
      SYNC: begin
        nxt_hs_en    = 1'b1;
        nxt_hs_data  = SYNC_BYTE;
        nxt_hs_valid = 1'b1;
      end
      DATA: begin
        nxt_hs_en = 1'b1;
        if (accept) begin
          nxt_hs_data  = byte_data;
          nxt_hs_valid = 1'b1;
        end else begin
          nxt_hs_data  = hs_data;
        end
      end
      TRAIL: begin
        nxt_hs_en    = 1'b1;
        nxt_hs_data  = {8{~last_msb}};
        nxt_hs_valid = 1'b1;
      end
      default: begin
        nxt_lp_dp = 1'b1;
        nxt_lp_dn = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_dp    <= 1'b1;
      lp_dn    <= 1'b1;
      hs_en    <= 1'b0;
      hs_data  <= 8'h00;
      hs_valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      lp_dp    <= nxt_lp_dp;
      lp_dn    <= nxt_lp_dn;
      hs_en    <= nxt_hs_en;
      hs_data  <= nxt_hs_data;
      hs_valid <= nxt_hs_valid;
      underrun <= nxt_underrun;
    end
  end

  // last_msb keeps bit 7 of the most recent payload byte for the trail pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_seen <= 1'b0;
      last_msb  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        last_seen <= 1'b0;
      end else if (accept && byte_last) begin
        last_seen <= 1'b1;
      end
      if (accept) begin
        last_msb <= byte_data[7];
      end
    end
  end

endmodule

// File: tb/tb_d_phy_hs_tx_sequencer.sv
// Self-checking bench for d_phy_hs_tx_sequencer: table-driven packet vectors
// plus directed sequences for async reset, back-to-back and ignored req.
module tb_d_phy_hs_tx_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic       lp_dp;
  logic       lp_dn;
  logic       hs_en;
  logic [7:0] hs_data;
  logic       hs_valid;
  logic       busy;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  d_phy_hs_tx_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_last (byte_last),
    .byte_ready(byte_ready),
    .lp_dp     (lp_dp),
    .lp_dn     (lp_dn),
    .hs_en     (hs_en),
    .hs_data   (hs_data),
    .hs_valid  (hs_valid),
    .busy      (busy),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record covers n consecutive cycles with constant inputs and outputs.
  typedef struct {
    int         n;
    logic       req;
    logic       valid;
    logic       last;
    logic [7:0] data;
    logic       dp;
    logic       dn;
    logic       en;
    logic [7:0] hd;
    logic       hv;
    logic       rdy;
    logic       busy;
    logic       und;
    logic       cd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int n, input logic r, input logic v, input logic l,
                              input logic [7:0] d, input logic dp, input logic dn,
                              input logic en, input logic [7:0] hd, input logic hv,
                              input logic rdy, input logic b, input logic und,
                              input logic cd);
    vec_t x;
    x.n = n; x.req = r; x.valid = v; x.last = l; x.data = d;
    x.dp = dp; x.dn = dn; x.en = en; x.hd = hd; x.hv = hv;
    x.rdy = rdy; x.busy = b; x.und = und; x.cd = cd;
    return x;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic l, input logic [7:0] d);
    req        = r;
    byte_valid = v;
    byte_last  = l;
    byte_data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check(name, {7'd0, busy}, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, 0, 8'h00);

    // Packet A: single byte 0x5A, trail 0xFF
    vecs.push_back(mk(1, 1,1,1,8'h5A, 1,1,0,8'h00,0,0,0,0,0));
    vecs.push_back(mk(4, 0,1,1,8'h5A, 0,1,0,8'h00,0,0,1,0,0));
    vecs.push_back(mk(4, 0,1,1,8'h5A, 0,0,0,8'h00,0,0,1,0,0));
    vecs.push_back(mk(6, 0,1,1,8'h5A, 0,0,1,8'h00,1,0,1,0,1));
    vecs.push_back(mk(1, 0,1,1,8'h5A, 0,0,1,8'hB8,1,1,1,0,1));
    vecs.push_back(mk(1, 0,1,1,8'h5A, 0,0,1,8'h5A,1,0,1,0,1));
    vecs.push_back(mk(5, 0,1,1,8'h5A, 0,0,1,8'hFF,1,0,1,0,1));
    vecs.push_back(mk(8, 0,1,1,8'h5A, 1,1,0,8'h00,0,0,1,0,0));
    vecs.push_back(mk(2, 0,0,0,8'h00, 1,1,0,8'h00,0,0,0,0,0));
    // Packet B: 01 02 03 84, trail 0x00
    vecs.push_back(mk(1, 1,1,0,8'h01, 1,1,0,8'h00,0,0,0,0,0));
    vecs.push_back(mk(4, 0,1,0,8'h01, 0,1,0,8'h00,0,0,1,0,0));
    vecs.push_back(mk(4, 0,1,0,8'h01, 0,0,0,8'h00,0,0,1,0,0));
    vecs.push_back(mk(6, 0,1,0,8'h01, 0,0,1,8'h00,1,0,1,0,1));
    vecs.push_back(mk(1, 0,1,0,8'h01, 0,0,1,8'hB8,1,1,1,0,1));
    vecs.push_back(mk(1, 0,1,0,8'h02, 0,0,1,8'h01,1,1,1,0,1));
    vecs.push_back(mk(1, 0,1,0,8'h03, 0,0,1,8'h02,1,1,1,0,1));
    vecs.push_back(mk(1, 0,1,1,8'h84, 0,0,1,8'h03,1,1,1,0,1));
    vecs.push_back(mk(1, 0,0,0,8'h00, 0,0,1,8'h84,1,0,1,0,1));
    vecs.push_back(mk(5, 0,0,0,8'h00, 0,0,1,8'h00,1,0,1,0,1));
    vecs.push_back(mk(8, 0,0,0,8'h00, 1,1,0,8'h00,0,0,1,0,0));
    vecs.push_back(mk(2, 0,0,0,8'h00, 1,1,0,8'h00,0,0,0,0,0));
    // Packet C: A1 B2 C3 with a valid gap on cycle 17
    vecs.push_back(mk(1, 1,1,0,8'hA1, 1,1,0,8'h00,0,0,0,0,0));
    vecs.push_back(mk(4, 0,1,0,8'hA1, 0,1,0,8'h00,0,0,1,0,0));
    vecs.push_back(mk(4, 0,1,0,8'hA1, 0,0,0,8'h00,0,0,1,0,0));
    vecs.push_back(mk(6, 0,1,0,8'hA1, 0,0,1,8'h00,1,0,1,0,1));
    vecs.push_back(mk(1, 0,1,0,8'hA1, 0,0,1,8'hB8,1,1,1,0,1));
    vecs.push_back(mk(1, 0,1,0,8'hB2, 0,0,1,8'hA1,1,1,1,0,1));
    vecs.push_back(mk(1, 0,0,0,8'hB2, 0,0,1,8'hB2,1,1,1,0,1));
    vecs.push_back(mk(1, 0,1,1,8'hC3, 0,0,1,8'hB2,0,1,1,1,1));
    vecs.push_back(mk(1, 0,0,0,8'h00, 0,0,1,8'hC3,1,0,1,0,1));
    vecs.push_back(mk(5, 0,0,0,8'h00, 0,0,1,8'h00,1,0,1,0,1));
    vecs.push_back(mk(8, 0,0,0,8'h00, 1,1,0,8'h00,0,0,1,0,0));
    vecs.push_back(mk(2, 0,0,0,8'h00, 1,1,0,8'h00,0,0,0,0,0));

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst.lp_dp",      {7'd0, lp_dp},      8'h01);
    check("rst.lp_dn",      {7'd0, lp_dn},      8'h01);
    check("rst.hs_en",      {7'd0, hs_en},      8'h00);
    check("rst.hs_data",    hs_data,            8'h00);
    check("rst.hs_valid",   {7'd0, hs_valid},   8'h00);
    check("rst.byte_ready", {7'd0, byte_ready}, 8'h00);
    check("rst.busy",       {7'd0, busy},       8'h00);
    check("rst.underrun",   {7'd0, underrun},   8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();

    // Idle with req low: nothing moves
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check($sformatf("idle%0d.lines", c), {5'd0, lp_dp, lp_dn, hs_en}, 8'h06);
      check($sformatf("idle%0d.busy", c),  {7'd0, busy}, 8'h00);
      step();
    end

    // Table-driven packets
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        drive(vecs[i].req, vecs[i].valid, vecs[i].last, vecs[i].data);
        @(negedge clk);
        check($sformatf("vec%0d.%0d.lp_dp", i, k),    {7'd0, lp_dp},      {7'd0, vecs[i].dp});
        check($sformatf("vec%0d.%0d.lp_dn", i, k),    {7'd0, lp_dn},      {7'd0, vecs[i].dn});
        check($sformatf("vec%0d.%0d.hs_en", i, k),    {7'd0, hs_en},      {7'd0, vecs[i].en});
        check($sformatf("vec%0d.%0d.hs_valid", i, k), {7'd0, hs_valid},   {7'd0, vecs[i].hv});
        check($sformatf("vec%0d.%0d.ready", i, k),    {7'd0, byte_ready}, {7'd0, vecs[i].rdy});
        check($sformatf("vec%0d.%0d.busy", i, k),     {7'd0, busy},       {7'd0, vecs[i].busy});
        check($sformatf("vec%0d.%0d.underrun", i, k), {7'd0, underrun},   {7'd0, vecs[i].und});
        if (vecs[i].cd)
          check($sformatf("vec%0d.%0d.hs_data", i, k), hs_data, vecs[i].hd);
        step();
      end
    end

    // Async reset mid-payload, then a clean restart
    drive(1, 1, 0, 8'h11);
    step();
    drive(0, 1, 0, 8'h11);
    repeat (16) step();
    check("ar.pre_hs_en", {7'd0, hs_en}, 8'h01);
    check("ar.pre_data",  hs_data,       8'h11);
    #2 rst_n = 1'b0;
    #1;
    check("ar.lines", {5'd0, lp_dp, lp_dn, hs_en}, 8'h06);
    check("ar.valid", {7'd0, hs_valid}, 8'h00);
    check("ar.busy",  {7'd0, busy},     8'h00);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1, 1, 8'h22);
    rst_n = 1'b1;
    step();
    drive(0, 1, 1, 8'h22);
    #1;
    check("ar.lp01", {5'd0, lp_dp, lp_dn, hs_en}, 8'h02);
    repeat (8) step();
    check("ar.hs_zero_en", {7'd0, hs_en}, 8'h01);
    repeat (6) step();
    check("ar.sync",  hs_data,            8'hB8);
    check("ar.ready", {7'd0, byte_ready}, 8'h01);
    step();
    check("ar.payload", hs_data, 8'h22);
    step();
    check("ar.trail", hs_data, 8'hFF);
    wait_idle("ar.idle");
    step();

    // Back-to-back with req held high: one IDLE cycle between packets
    for (int c = 0; c < 50; c++) begin
      drive(1, 1, (c == 16) || (c == 48), 8'(c));
      @(negedge clk);
      if (c == 30) check("b2b.exit_busy", {7'd0, busy}, 8'h01);
      if (c == 30) check("b2b.exit_lines", {5'd0, lp_dp, lp_dn, hs_en}, 8'h06);
      if (c == 31) check("b2b.idle_busy", {7'd0, busy}, 8'h00);
      if (c == 32) check("b2b.lp01", {5'd0, lp_dp, lp_dn, hs_en}, 8'h02);
      if (c == 32) check("b2b.lp01_busy", {7'd0, busy}, 8'h01);
      if (c == 48) check("b2b.byte0", hs_data, 8'h2F);
      if (c == 49) check("b2b.byte1", hs_data, 8'h30);
      step();
    end
    drive(0, 0, 0, 8'h00);
    #1;
    check("b2b.trail", hs_data, 8'hFF);
    wait_idle("b2b.idle");
    step();

    // req pulsed during DATA is ignored
    for (int c = 0; c < 33; c++) begin
      drive((c == 0) || (c == 16), 1, (c == 16), 8'h40 + 8'(c));
      @(negedge clk);
      if (c == 16) check("rp.data", hs_data, 8'h4F);
      if (c == 31) check("rp.idle31", {7'd0, busy}, 8'h00);
      if (c == 32) check("rp.idle32", {7'd0, busy}, 8'h00);
      if (c == 32) check("rp.lines32", {5'd0, lp_dp, lp_dn, hs_en}, 8'h06);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
